hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Central pipeline sequencing controller for the 5-stage core. It generates the enable (stall) and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are load-use hazards, EX-stage branch redirects and a multi-cycle data-memory handshake in MEM. It sits beside the datapath, and its outputs drive each pipeline register's `en`/`flush` pins directly.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum number of MEM_WAIT cycles before the access is aborted (range 2..255).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs1_id`, `rs2_id` in 5 each: source register indices of the instruction in ID.
- `rs1_used_id`, `rs2_used_id` in 1 each: the corresponding source is actually read.
- `rd_ex` in 5: destination register index in EX.
- `mem_read_ex` in 1: the instruction in EX is a load.
- `redirect_ex` in 1: branch/jump resolved in EX with a PC redirect.
- `mem_read_mem`, `mem_write_mem` in 1 each: MEM stage is accessing data memory.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: stage advance enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1 each: bubble insertion.
- `dmem_timeout` out 1: one-cycle pulse when an access is aborted.
- `stall_cycles`, `flush_events` out `CNT_W` each: perf counters (macro-gated).

## Operation
- **Hazard terms** (combinational):
  - `load_use` = `mem_read_ex` & `rd_ex`≠0 & ((`rs1_used_id` & `rs1_id`==`rd_ex`) | (`rs2_used_id` & `rs2_id`==`rd_ex`)).
  - `mem_busy` = (`mem_read_mem`|`mem_write_mem`) & !`dmem_ready`.
- **FSM states:** RUN, MEM_WAIT, ABORT. Reset state is RUN. The wait counter `wcnt` (8 bits) resets to 0.
- **RUN:**
  - If `mem_busy`: go to MEM_WAIT, `wcnt`←1.
  - Else stay in RUN.
- **MEM_WAIT:**
  - If `dmem_ready`: go to RUN, `wcnt`←0.
  - Else if `wcnt`==`MEM_TIMEOUT`-1: go to ABORT.
  - Else `wcnt`++.
- **ABORT:** lasts exactly one cycle, then RUN with `wcnt`←0.
- **Output priority** (highest first). Unlisted enables are 1 and unlisted flushes are 0.
  1. ABORT: `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=`mem_wb_flush`=1 and `dmem_timeout`=1. The PC advances, so the trap redirect is handled upstream.
  2. `mem_busy` (either RUN or MEM_WAIT): `pc_en`=`if_id_en`=`id_ex_en`=`ex_mem_en`=0 and `mem_wb_flush`=1. All flushes other than `mem_wb_flush` are forced to 0, and any redirect or load_use is deferred.
  3. `redirect_ex`: `if_id_flush`=`id_ex_flush`=1. This overrides a simultaneous load_use, because the ID instruction is wrong-path.
  4. `load_use`: `pc_en`=`if_id_en`=0 and `id_ex_flush`=1.
- Flush takes precedence over enable inside the register, so the controller never needs to deassert `en` when it asserts a flush.
- **While `rst`=1:** all enables are 0, all flushes are 0, `dmem_timeout`=0 and the counters are 0.
- **`rst` asserted mid-MEM_WAIT:** the FSM is in RUN on the first edge after release and no abort pulse is produced.

## Timing
- All outputs are combinational from the registered state plus the current inputs. They are valid in the same cycle as the hazard (zero latency).
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has moved to MEM, so `load_use` deasserts.
- Memory handshake: the access completes on the first cycle with `dmem_ready`=1. Those enables are 1 in that same cycle.
- Maximum stall per access is `MEM_TIMEOUT` cycles, followed by 1 ABORT cycle.
- A `dmem_ready` arriving in the ABORT cycle is ignored.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:**
  - `stall_cycles` increments on every cycle where `pc_en`=0 outside reset.
  - `flush_events` increments on every cycle where any flush is 1.
  - Both counters wrap modulo 2^`CNT_W`.
- **Not defined:** both outputs are tied to 0 and no counter flops are synthesized.

## Structure
- Shared package `core_pkg`:
  - State enum `hz_state_t` {RUN, MEM_WAIT, ABORT}.
  - Register-index width `REG_AW`=5.
  - Constant `X0`=5'd0.
- Sub-module `load_use_detect` holds the purely combinational `load_use` compare. It is reused by the forwarding unit.
- The FSM, wait counter and perf counters stay in the top module.

## Test plan
- **Load-use:** EX: lw x5; ID: add x6,x5,x1 (`rs1_used_id`=1) -> 1 cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; the next cycle has no stall. Repeat with `rd_ex`=0 -> no stall.
- **Redirect plus load-use in the same cycle** -> `if_id_flush`=`id_ex_flush`=1 and `pc_en`=1.
- **Load with `dmem_ready` low for 3 cycles, then high** -> 3 cycles with the four enables at 0 and `mem_wb_flush`=1; the 4th cycle has all enables at 1; the FSM sequence is RUN, MEM_WAIT×3, RUN.
- **`MEM_TIMEOUT`=4, `dmem_ready` held low** -> ABORT on the 5th cycle of the access with all four flushes and `dmem_timeout`=1 for one cycle; the FSM then returns to RUN.
- **`redirect_ex` during MEM_WAIT** -> no flush until `dmem_ready`; the flush appears in the release cycle if `redirect_ex` is still held.
- **`rst` pulse in MEM_WAIT (`wcnt`=2)** -> all outputs are 0 during reset; after release the FSM is in RUN with `wcnt`=0. With `HAZARD_PERF_CNT_EN` defined, the counters read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants for the 5-stage core.
package core_pkg;

    localparam int REG_AW = 5;
    localparam int WCNT_W = 8;
    localparam logic [REG_AW-1:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
module load_use_detect
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_ex,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used_id && (rs1_id == rd_ex);
    assign rs2_hit  = rs2_used_id && (rs2_id == rd_ex);
    // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
    assign load_use = mem_read_ex && (rd_ex != X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use, EX redirect and data-memory wait/timeout.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_ex,
    input  logic              redirect_ex,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              dmem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_reg, state_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic              load_use;
    logic              mem_busy;
    logic              any_flush;

    load_use_detect u_load_use_detect (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .rd_ex       (rd_ex),
        .mem_read_ex (mem_read_ex),
        .load_use    (load_use)
    );

    assign mem_busy = (mem_read_mem || mem_write_mem) && !dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_busy) begin
                    state_next = MEM_WAIT;
                    wcnt_next  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                    wcnt_next  = '0;
                end else if (wcnt_reg == WAIT_LAST) begin
                    state_next = ABORT;
                end else begin
                    wcnt_next = wcnt_reg + WCNT_W'(1);
                end
            end
            // A dmem_ready arriving here is deliberately ignored.
            ABORT: begin
                state_next = RUN;
                wcnt_next  = '0;
            end
            default: begin
                state_next = RUN;
                wcnt_next  = '0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_timeout = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state_reg == ABORT) begin
            // PC keeps advancing; the trap redirect is injected upstream.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            dmem_timeout = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything up to MEM; redirect and load-use wait for release.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redirect_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign any_flush = if_id_flush || id_ex_flush || ex_mem_flush || mem_wb_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (any_flush) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_events = flush_cnt_reg;
`else
    logic unused_flush;
    assign unused_flush = any_flush;
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl (MEM_TIMEOUT=4 to reach the abort path quickly).
module tb_hazard_stall_ctrl;
    import core_pkg::*;

    localparam int CNT_W = 32;

    // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush | timeout}
    localparam logic [9:0] C_RST      = 10'b00000_0000_0;
    localparam logic [9:0] C_NORMAL   = 10'b11111_0000_0;
    localparam logic [9:0] C_LOADUSE  = 10'b00111_0100_0;
    localparam logic [9:0] C_REDIRECT = 10'b11111_1100_0;
    localparam logic [9:0] C_MEMBUSY  = 10'b00001_0001_0;
    localparam logic [9:0] C_ABORT    = 10'b11111_1111_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_id, rs2_id, rd_ex;
    logic             rs1_used_id, rs2_used_id, mem_read_ex, redirect_ex;
    logic             mem_read_mem, mem_write_mem, dmem_ready;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, dmem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [9:0]       ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used_id   (rs1_used_id),
        .rs2_used_id   (rs2_used_id),
        .rd_ex         (rd_ex),
        .mem_read_ex   (mem_read_ex),
        .redirect_ex   (redirect_ex),
        .mem_read_mem  (mem_read_mem),
        .mem_write_mem (mem_write_mem),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .dmem_timeout  (dmem_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, dmem_timeout};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        redirect_ex = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lw_x5_add();
        mem_read_ex = 1'b1; rd_ex = 5'd5;
        rs1_id = 5'd5; rs1_used_id = 1'b1;
        rs2_id = 5'd1; rs2_used_id = 1'b1;
    endtask

    task automatic check_counters(input string tag, input int stalls, input int flushes);
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, "_stall_cnt"}, 64'(stall_cycles), 64'(stalls));
        check_eq({tag, "_flush_cnt"}, 64'(flush_events), 64'(flushes));
`else
        check_eq({tag, "_stall_cnt"}, 64'(stall_cycles), 64'(0 * stalls));
        check_eq({tag, "_flush_cnt"}, 64'(flush_events), 64'(0 * flushes));
`endif
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        set_lw_x5_add();
        mem_read_mem = 1'b1;
        #2;
        check_eq("rst_outputs", 64'(ctl), 64'(C_RST));
        check_counters("rst", 0, 0);

        next_cycle();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        check_eq("idle", 64'(ctl), 64'(C_NORMAL));
        check_eq("idle_state", 64'(dut.state_reg), 64'(RUN));

        // lw x5 in EX, add x6,x5,x1 in ID
        next_cycle();
        set_lw_x5_add();
        @(negedge clk);
        check_eq("load_use_rs1", 64'(ctl), 64'(C_LOADUSE));

        next_cycle();
        set_idle();
        rd_ex = 5'd6; mem_read_mem = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("load_use_released", 64'(ctl), 64'(C_NORMAL));

        next_cycle();
        set_idle();
        mem_read_ex = 1'b1; rs1_used_id = 1'b1; rs2_used_id = 1'b1;
        @(negedge clk);
        check_eq("load_use_x0", 64'(ctl), 64'(C_NORMAL));

        next_cycle();
        set_idle();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd3; rs1_used_id = 1'b1; rs2_id = 5'd7;
        @(negedge clk);
        check_eq("load_use_rs2_unused", 64'(ctl), 64'(C_NORMAL));

        next_cycle();
        rs2_used_id = 1'b1;
        @(negedge clk);
        check_eq("load_use_rs2", 64'(ctl), 64'(C_LOADUSE));

        next_cycle();
        mem_read_ex = 1'b0;
        @(negedge clk);
        check_eq("not_a_load", 64'(ctl), 64'(C_NORMAL));

        next_cycle();
        set_idle();
        set_lw_x5_add();
        redirect_ex = 1'b1;
        @(negedge clk);
        check_eq("redirect_over_load_use", 64'(ctl), 64'(C_REDIRECT));

        // Load with dmem_ready low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_idle();
            mem_read_mem = 1'b1;
            @(negedge clk);
            check_eq($sformatf("wait3_busy%0d", i), 64'(ctl), 64'(C_MEMBUSY));
            check_eq($sformatf("wait3_state%0d", i), 64'(dut.state_reg),
                     64'((i == 0) ? RUN : MEM_WAIT));
        end
        next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("wait3_release", 64'(ctl), 64'(C_NORMAL));
        check_eq("wait3_release_state", 64'(dut.state_reg), 64'(MEM_WAIT));
        next_cycle();
        set_idle();
        @(negedge clk);
        check_eq("wait3_back_run", 64'(dut.state_reg), 64'(RUN));

        // Timeout with MEM_TIMEOUT=4
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_idle();
            mem_write_mem = 1'b1;
            @(negedge clk);
            check_eq($sformatf("tmo_busy%0d", i), 64'(ctl), 64'(C_MEMBUSY));
        end
        next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("tmo_abort", 64'(ctl), 64'(C_ABORT));
        check_eq("tmo_abort_state", 64'(dut.state_reg), 64'(ABORT));
        next_cycle();
        set_idle();
        @(negedge clk);
        check_eq("tmo_after", 64'(ctl), 64'(C_NORMAL));
        check_eq("tmo_after_state", 64'(dut.state_reg), 64'(RUN));
        check_eq("tmo_after_wcnt", 64'(dut.wcnt_reg), 64'(0));

        // Redirect held during a memory wait is deferred to the release cycle
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            set_idle();
            mem_read_mem = 1'b1; redirect_ex = 1'b1;
            @(negedge clk);
            check_eq($sformatf("redir_wait%0d", i), 64'(ctl), 64'(C_MEMBUSY));
        end
        next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("redir_release", 64'(ctl), 64'(C_REDIRECT));
        next_cycle();
        set_idle();
        @(negedge clk);
        check_eq("redir_idle", 64'(ctl), 64'(C_NORMAL));

        // Reset pulse while MEM_WAIT with wcnt=2
        next_cycle();
        mem_read_mem = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rstw_pre_wcnt", 64'(dut.wcnt_reg), 64'(2));
        #1;
        rst = 1'b1;
        #1;
        check_eq("rstw_outputs", 64'(ctl), 64'(C_RST));
        next_cycle();
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_state", 64'(dut.state_reg), 64'(RUN));
        check_eq("rstw_wcnt", 64'(dut.wcnt_reg), 64'(0));
        check_eq("rstw_outs", 64'(ctl), 64'(C_NORMAL));
        check_counters("rstw", 0, 0);

        next_cycle();
        set_lw_x5_add();
        @(negedge clk);
        check_eq("post_rst_load_use", 64'(ctl), 64'(C_LOADUSE));
        next_cycle();
        set_idle();
        @(negedge clk);
        check_eq("post_rst_no_abort", 64'(ctl), 64'(C_NORMAL));
        check_counters("post_rst", 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
